imem_boot_loader: RTL and testbench

//  Upstream of the single-cycle MIPS core: fills instruction memory from a byte stream before the core runs.

---
 rtl/imem_boot_loader.sv | 156 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed byte stream (LEN_HI, LEN_LO, 4*LEN payload
// bytes, XOR checksum), assembles big-endian 32-bit words and writes them to
// consecutive instruction-memory word addresses. The MIPS core is held in reset
// until a frame with a good checksum has been loaded.
module imem_boot_loader #(
   parameter int          MAX_WORDS = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_rst,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   // Widened by one bit so a 16-bit length can be compared without truncation.
   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   state_t      state;
   logic [7:0]  len_hi;      // high length byte, held until LEN_LO arrives
   logic [15:0] words_left;  // words still to be received in DATA
   logic [1:0]  byte_cnt;    // byte position inside the current word
   logic [23:0] word_buf;    // first three bytes of the word being assembled
   logic [7:0]  checksum;    // running XOR of payload bytes
   logic        accept;
   logic [15:0] len_rx;

   // Handshake and busy flags decode the state directly so a byte is never
   // offered a cycle late.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through it can leave a value held and infer a latch.
      in_ready = 1'b0;
      case (state)
         S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: in_ready = 1'b1;
         default:                             in_ready = 1'b0;
      endcase
      busy   = in_ready;
      accept = in_valid & in_ready;
      len_rx = {len_hi, in_data};
   end

   // Frame state machine with registered memory-write and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         len_hi     <= '0;
         words_left <= '0;
         byte_cnt   <= '0;
         word_buf   <= '0;
         checksum   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= '0;
         cpu_rst    <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         // A write strobe lasts one cycle; the address advances as it drops,
         // which lets the next word's bytes arrive without a stall.
         if (imem_we) begin
            imem_we   <= 1'b0;
            imem_addr <= imem_addr + 32'd4;
         end

         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state      <= S_LEN_HI;
                  len_hi     <= '0;
                  words_left <= '0;
                  byte_cnt   <= '0;
                  checksum   <= '0;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  cpu_rst    <= 1'b1;
                  imem_addr  <= BASE_ADDR;
               end
            end

            S_LEN_HI: begin
               if (accept) begin
                  len_hi <= in_data;
                  state  <= S_LEN_LO;
               end
            end

            S_LEN_LO: begin
               if (accept) begin
                  words_left <= len_rx;
                  if ({1'b0, len_rx} > MAX_LEN) begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end else if (len_rx == 16'd0) begin
                     state <= S_CHECK;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (accept) begin
                  checksum <= checksum ^ in_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  word_buf <= {word_buf[15:0], in_data};
                  if (byte_cnt == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_wdata <= {word_buf, in_data};
                     words_left <= words_left - 16'd1;
                     if (words_left == 16'd1) begin
                        state <= S_CHECK;
                     end
                  end
               end
            end

            S_CHECK: begin
               if (accept) begin
                  if (in_data == checksum) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     cpu_rst <= 1'b0;
                  end else begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a table of frame descriptions plus randomized
// frames, each checked against a frame-level reference model (expected write
// list and final status computed from the payload words), and hand-written
// sequences for continuous streaming, reset mid-frame and start while busy.
module tb_imem_boot_loader;

   localparam int          MAX  = 256;
   localparam logic [31:0] BASE = 32'h0000_0040;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        error;

   int total = 0;
   int bad   = 0;

   logic [31:0] pay_q[$];      // payload words of the frame being sent
   logic [31:0] wr_addr_q[$];  // observed writes
   logic [31:0] wr_data_q[$];

   typedef struct {
      int len;
      bit bad_chk;
      bit gap;
      bit exp_done;
      bit exp_error;
      int exp_writes;
   } vec_t;

   imem_boot_loader #(.MAX_WORDS(MAX), .BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   // Record every write strobe, sampled mid-cycle.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Present one byte; returns 1 ns after the edge that accepted it.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int  n  = 0;
      bit  ok = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      while (!ok && n < 64) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
         end else begin
            n++;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL send_byte_timeout: got no in_ready want in_ready for byte 0x%02h", b);
         in_valid = 1'b0;
      end else if (gap) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_cpu_rst"},    32'(cpu_rst),  32'd1);
      check({tag, "_imem_we"},    32'(imem_we),  32'd0);
      check({tag, "_imem_addr"},  imem_addr,     BASE);
      check({tag, "_imem_wdata"}, imem_wdata,    32'd0);
      check({tag, "_in_ready"},   32'(in_ready), 32'd0);
      check({tag, "_busy"},       32'(busy),     32'd0);
      check({tag, "_done"},       32'(done),     32'd0);
      check({tag, "_error"},      32'(error),    32'd0);
   endtask

   // Send one complete frame built from pay_q and compare against the model.
   task automatic run_frame(input int len, input bit bad_chk, input bit gap,
                            input bit mid_start, input bit exp_done,
                            input bit exp_error, input int exp_writes,
                            input string name);
      logic [7:0]  chk;
      logic [7:0]  len_b;
      logic [31:0] w;
      logic [15:0] len16;
      int          nw;
      chk   = 8'h00;
      len16 = 16'(len);
      wr_addr_q.delete();
      wr_data_q.delete();

      pulse_start();
      @(negedge clk);
      check({name, "_busy_start"},    32'(busy),    32'd1);
      check({name, "_cpu_rst_start"}, 32'(cpu_rst), 32'd1);
      check({name, "_done_start"},    32'(done),    32'd0);
      @(posedge clk); #1;

      len_b = len16[15:8];
      send_byte(len_b, gap);
      len_b = len16[7:0];
      send_byte(len_b, gap);
      in_valid = 1'b0;

      if (len > MAX) begin
         @(negedge clk);
         check({name, "_len_error"},    32'(error),    32'd1);
         check({name, "_len_in_ready"}, 32'(in_ready), 32'd0);
         check({name, "_len_cpu_rst"},  32'(cpu_rst),  32'd1);
         repeat (3) @(negedge clk);
         check({name, "_len_nwrites"},  32'(wr_addr_q.size()), 32'd0);
         @(posedge clk); #1;
         return;
      end

      if (mid_start) begin
         pulse_start();
         @(negedge clk);
         check({name, "_busy_after_start"}, 32'(busy), 32'd1);
         @(posedge clk); #1;
      end

      for (int i = 0; i < len; i++) begin
         w = pay_q[i];
         for (int k = 3; k >= 0; k--) begin
            chk = chk ^ w[8*k +: 8];
            send_byte(w[8*k +: 8], gap);
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      check({name, "_cpu_rst_pre_chk"}, 32'(cpu_rst), 32'd1);
      check({name, "_done_pre_chk"},    32'(done),    32'd0);
      @(posedge clk); #1;

      if (bad_chk) chk = chk ^ 8'(1 + $urandom_range(0, 254));
      send_byte(chk, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      check({name, "_done"},     32'(done),     32'(exp_done));
      check({name, "_error"},    32'(error),    32'(exp_error));
      check({name, "_cpu_rst"},  32'(cpu_rst),  32'(!exp_done));
      check({name, "_busy_end"}, 32'(busy),     32'd0);
      check({name, "_ready_end"},32'(in_ready), 32'd0);
      check({name, "_nwrites"},  32'(wr_addr_q.size()), 32'(exp_writes));
      nw = (wr_addr_q.size() < len) ? wr_addr_q.size() : len;
      for (int i = 0; i < nw; i++) begin
         check({name, "_waddr"}, wr_addr_q[i], BASE + 32'(4 * i));
         check({name, "_wdata"}, wr_data_q[i], pay_q[i]);
      end
      @(posedge clk); #1;
   endtask

   // Frame of one word streamed with in_valid held high throughout.
   task automatic stream_one(input logic [7:0] chk_byte, input bit exp_ok, input string name);
      logic [7:0] frame [6];
      frame[0] = 8'h00; frame[1] = 8'h01; frame[2] = 8'h20;
      frame[3] = 8'h08; frame[4] = 8'h00; frame[5] = 8'h05;
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(frame[i], 1'b0);
      check({name, "_we_latency"}, 32'(imem_we),   32'd1);
      check({name, "_we_addr"},    imem_addr,      BASE);
      check({name, "_we_data"},    imem_wdata,     32'h2008_0005);
      check({name, "_cpu_rst_mid"},32'(cpu_rst),   32'd1);
      send_byte(chk_byte, 1'b0);
      in_valid = 1'b0;
      check({name, "_we_dropped"}, 32'(imem_we),   32'd0);
      check({name, "_addr_inc"},   imem_addr,      BASE + 32'd4);
      check({name, "_done"},       32'(done),      32'(exp_ok));
      check({name, "_error"},      32'(error),     32'(!exp_ok));
      check({name, "_cpu_rst"},    32'(cpu_rst),   32'(!exp_ok));
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t vecs [8];
      int   len;
      bit   bc;
      bit   gp;

      vecs[0] = '{len: 0,       bad_chk: 0, gap: 0, exp_done: 1, exp_error: 0, exp_writes: 0};
      vecs[1] = '{len: 1,       bad_chk: 0, gap: 0, exp_done: 1, exp_error: 0, exp_writes: 1};
      vecs[2] = '{len: MAX + 1, bad_chk: 0, gap: 0, exp_done: 0, exp_error: 1, exp_writes: 0};
      vecs[3] = '{len: 0,       bad_chk: 1, gap: 1, exp_done: 0, exp_error: 1, exp_writes: 0};
      vecs[4] = '{len: 3,       bad_chk: 1, gap: 1, exp_done: 0, exp_error: 1, exp_writes: 3};
      vecs[5] = '{len: MAX,     bad_chk: 0, gap: 0, exp_done: 1, exp_error: 0, exp_writes: MAX};
      vecs[6] = '{len: 65535,   bad_chk: 0, gap: 1, exp_done: 0, exp_error: 1, exp_writes: 0};
      vecs[7] = '{len: 5,       bad_chk: 0, gap: 1, exp_done: 1, exp_error: 0, exp_writes: 5};

      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #12;
      check_reset_values("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Continuous stream, good and bad checksum.
      stream_one(8'h2D, 1'b1, "s1");
      stream_one(8'h00, 1'b0, "s3");

      // Two words with in_valid toggling and a start pulse while busy.
      pay_q = '{32'h8C01_0004, 32'hAC02_0008};
      run_frame(2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2, "s2");

      // Table of frames; vecs[0] followed by vecs[1] is the empty-then-reload case.
      for (int v = 0; v < 8; v++) begin
         pay_q.delete();
         if (v == 1) pay_q.push_back(32'h2008_0005);
         else if (vecs[v].len <= MAX)
            for (int i = 0; i < vecs[v].len; i++) pay_q.push_back($urandom);
         run_frame(vecs[v].len, vecs[v].bad_chk, vecs[v].gap, 1'b0,
                   vecs[v].exp_done, vecs[v].exp_error, vecs[v].exp_writes, $sformatf("vec%0d", v));
      end

      // Randomized frames against the model.
      for (int r = 0; r < 8; r++) begin
         len = $urandom_range(0, 10);
         bc  = ($urandom_range(0, 3) == 0);
         gp  = 1'($urandom_range(0, 1));
         pay_q.delete();
         for (int i = 0; i < len; i++) pay_q.push_back($urandom);
         run_frame(len, bc, gp, 1'b0, !bc, bc, len, $sformatf("rand%0d", r));
      end

      // Reset after two payload bytes, then a full reload.
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_reset_values("midrst");
      #2 rst = 1'b0;
      @(posedge clk); #1;
      pay_q = '{32'h1122_3344};
      run_frame(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, "s6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
